// File: rtl/ifm_stream_reader_3x3_if.sv
// ifm_stream_reader_3x3_if: control, memory-read and pixel-stream signals of the IFM reader
interface ifm_stream_reader_3x3_if #(parameter int ADDR_W = 16);
  logic start;
  logic [2:0] sel_in;
  logic [ADDR_W-1:0] base_addr;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] sel;
  logic [7:0] pix_out;
  logic pix_valid;
  logic win_valid;
  logic [7:0] win_row;
  logic [7:0] win_col;
  logic busy;
  logic done;
  logic err;
  modport master (
    input start, sel_in, base_addr, rd_data,
    output rd_en, rd_addr, sel, pix_out, pix_valid, win_valid, win_row, win_col, busy, done, err
  );
  modport slave (
    output start, sel_in, base_addr, rd_data,
    input rd_en, rd_addr, sel, pix_out, pix_valid, win_valid, win_row, win_col, busy, done, err
  );
endinterface

// File: rtl/ifm_stream_reader_3x3.sv
// ifm_stream_reader_3x3: raster IFM reader feeding a 3x3 line buffer with window strobes
// IFM_ZERO_PAD_EN streams a (W+2)x(W+2) frame with a zero border
module ifm_stream_reader_3x3 #(
  parameter int ADDR_W = 16,
  parameter int W0 = 8,
  parameter int W1 = 14,
  parameter int W2 = 28,
  parameter int W3 = 56,
  parameter int W4 = 112,
  parameter int W5 = 224
) (
  input logic clk,
  input logic rst,
  ifm_stream_reader_3x3_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] sel_q;
  logic [ADDR_W-1:0] base, ofs;
  logic [7:0] r, c, wsz, len, r2, c2, r3, c3, pix_out, win_row, win_col;
  logic [1:0] dcnt;
  logic accept, last, border, rd_en, v2, b2, pix_valid, win_valid, err, win_hit;
  assign wsz = sel_q == 3'd0 ? 8'(W0) :
               sel_q == 3'd1 ? 8'(W1) :
               sel_q == 3'd2 ? 8'(W2) :
               sel_q == 3'd3 ? 8'(W3) :
               sel_q == 3'd4 ? 8'(W4) : 8'(W5);
`ifdef IFM_ZERO_PAD_EN
  assign len = wsz + 8'd2;
  assign border = r == 8'd0 || c == 8'd0 || r == len - 8'd1 || c == len - 8'd1;
`else
  assign len = wsz;
  assign border = 1'b0;
`endif
  assign accept = state == IDLE && bus.start && bus.sel_in <= 3'd5;
  assign last = r == len - 8'd1 && c == len - 8'd1;
  assign rd_en = state == RUN && !border;
  assign win_hit = pix_valid && r3 >= 8'd2 && c3 >= 8'd2;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? RUN : IDLE;
      RUN: state_nx = last ? DRAIN : RUN;
      DRAIN: state_nx = dcnt == 2'd2 ? DONE : DRAIN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      base <= '0;
      ofs <= '0;
      r <= '0;
      c <= '0;
      dcnt <= '0;
      v2 <= 1'b0;
      b2 <= 1'b0;
      r2 <= '0;
      c2 <= '0;
      r3 <= '0;
      c3 <= '0;
      pix_valid <= 1'b0;
      pix_out <= '0;
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      err <= state == IDLE && bus.start && bus.sel_in > 3'd5;
      if (accept) begin
        sel_q <= bus.sel_in;
        base <= bus.base_addr;
        ofs <= '0;
        r <= '0;
        c <= '0;
      end else if (state == RUN) begin
        c <= c == len - 8'd1 ? 8'd0 : c + 8'd1;
        r <= c == len - 8'd1 ? r + 8'd1 : r;
        ofs <= border ? ofs : ofs + ADDR_W'(1);
      end
      dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
      // pipeline stage aligned with rd_data, then the registered pixel, then the window
      v2 <= state == RUN;
      b2 <= border;
      r2 <= r;
      c2 <= c;
      pix_valid <= v2;
      pix_out <= (v2 && !b2) ? bus.rd_data : 8'd0;
      r3 <= r2;
      c3 <= c2;
      win_valid <= win_hit;
      if (win_hit) begin
        win_row <= r3 - 8'd2;
        win_col <= c3 - 8'd2;
      end
    end
  end
  assign bus.rd_en = rd_en;
  assign bus.rd_addr = rd_en ? base + ofs : '0;
  assign bus.sel = sel_q;
  assign bus.pix_out = pix_out;
  assign bus.pix_valid = pix_valid;
  assign bus.win_valid = win_valid;
  assign bus.win_row = win_row;
  assign bus.win_col = win_col;
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.err = err;
endmodule

// File: tb/tb_ifm_stream_reader_3x3.sv
// tb_ifm_stream_reader_3x3: directed cycle-by-cycle checks of the IFM reader against timing formulas
module tb_ifm_stream_reader_3x3;
`ifdef IFM_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int hr = 0;
  int hc = 0;
  always #5 clk = ~clk;
  ifm_stream_reader_3x3_if #(.ADDR_W(16)) bus ();
  ifm_stream_reader_3x3 #(.ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  // memory holds value = low byte of address, one cycle read latency
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic bit is_border(input int p, input int f);
    int fr, fc;
    fr = p / f;
    fc = p % f;
    return PAD == 1 && (fr == 0 || fc == 0 || fr == f - 1 || fc == f - 1);
  endfunction
  function automatic logic [15:0] addr_of(input logic [15:0] b, input int w, input int f, input int p);
    return b + 16'(((p / f) - PAD) * w + (p % f) - PAD);
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, "_pix_out"}, 32'(bus.pix_out), 0);
    chk({tag, "_win_valid"}, 32'(bus.win_valid), 0);
    chk({tag, "_win_row"}, 32'(bus.win_row), 0);
    chk({tag, "_win_col"}, 32'(bus.win_col), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_sel"}, 32'(bus.sel), 0);
  endtask
  task automatic xfer(input logic [2:0] s, input logic [15:0] b, input int w, input int spur, input int abort_at);
    int f, n, wins, first_t, last_t, pv_cnt, rd_cnt, q, m;
    bit iss, strm, wv;
    logic [15:0] a;
    logic [7:0] pv;
    f = w + 2 * PAD;
    n = f * f;
    wins = 0;
    first_t = 0;
    last_t = 0;
    pv_cnt = 0;
    rd_cnt = 0;
    bus.start = 1'b1;
    bus.sel_in = s;
    bus.base_addr = b;
    step();
    bus.start = 1'b0;
    for (int t = 1; t <= n + 5; t++) begin
      iss = t - 1 < n && !is_border(t - 1, f);
      chk("rd_en", 32'(bus.rd_en), 32'(iss));
      if (iss) begin
        a = addr_of(b, w, f, t - 1);
        chk("rd_addr", 32'(bus.rd_addr), 32'(a));
        rd_cnt++;
      end
      q = t - 3;
      strm = q >= 0 && q < n;
      pv = 8'd0;
      if (strm && !is_border(q, f)) begin
        a = addr_of(b, w, f, q);
        pv = a[7:0];
      end
      chk("pix_valid", 32'(bus.pix_valid), 32'(strm));
      chk("pix_out", 32'(bus.pix_out), 32'(pv));
      if (bus.pix_valid) pv_cnt++;
      m = t - 4;
      wv = m >= 0 && m < n && m / f >= 2 && m % f >= 2;
      if (wv) begin
        hr = m / f - 2;
        hc = m % f - 2;
        wins++;
        if (first_t == 0) first_t = t;
        last_t = t;
      end
      chk("win_valid", 32'(bus.win_valid), 32'(wv));
      chk("win_row", 32'(bus.win_row), hr);
      chk("win_col", 32'(bus.win_col), hc);
      chk("busy", 32'(bus.busy), 32'(t <= n + 3));
      chk("done", 32'(bus.done), 32'(t == n + 4));
      chk("sel", 32'(bus.sel), 32'(s));
      chk("err", 32'(bus.err), 0);
      if (t == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("abort");
        hr = 0;
        hc = 0;
        return;
      end
      if (t == spur) begin
        bus.start = 1'b1;
        bus.sel_in = 3'd2;
        bus.base_addr = 16'h1234;
      end else bus.start = 1'b0;
      step();
    end
    chk("win_count", wins, (f - 2) * (f - 2));
    chk("first_win_cycle", first_t, 2 * f + 6);
    chk("last_win_cycle", last_t, n + 3);
    chk("pix_count", pv_cnt, n);
    chk("rd_count", rd_cnt, w * w);
    if (w > 0) chk("first_win_pos", 32'(first_t > 0), 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sel_in = 3'd0;
    bus.base_addr = 16'h0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check_zero("idle");
    xfer(3'd0, 16'h0000, 8, 0, 0);
    xfer(3'd0, 16'hFFF8, 8, 20, 0);
    bus.sel_in = 3'd6;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("err_pulse", 32'(bus.err), 1);
    chk("err_busy", 32'(bus.busy), 0);
    chk("err_rd_en", 32'(bus.rd_en), 0);
    chk("err_done", 32'(bus.done), 0);
    chk("err_sel_held", 32'(bus.sel), 0);
    step();
    chk("err_clear", 32'(bus.err), 0);
    chk("err_busy2", 32'(bus.busy), 0);
    chk("err_rd_en2", 32'(bus.rd_en), 0);
    xfer(3'd1, 16'h0100, 14, 0, 30);
    step();
    check_zero("post_abort");
    xfer(3'd1, 16'h0200, 14, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
